mem_stage: RTL and testbench

//  MEM stage of the 5-stage MIPS pipeline, fed directly by the EX/MEM register and driving the WB stage.

---
 rtl/mem_stage_pkg.sv | 25 ++
 rtl/data_memory.sv | 27 ++
 rtl/mem_stage.sv | 133 +++++++++++++
 tb/tb_mem_stage.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared widths, FSM encoding and MEM/WB payload for the MEM stage.
package mem_stage_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned REG_W  = 5;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    typedef struct packed {
        logic              reg_write;
        logic              memto_reg;
        logic [DATA_W-1:0] read_data;
        logic [DATA_W-1:0] alu_result;
        logic [REG_W-1:0]  dst;
    } memwb_t;

    // Wait counter width; a zero-latency build still keeps a 1-bit counter.
    function automatic int unsigned cnt_width(input int unsigned lat);
        return (lat == 0) ? 1 : $clog2(lat + 1);
    endfunction

endpackage

// File: rtl/data_memory.sv
// Word-addressed data RAM: synchronous write with enable, asynchronous read, no reset.
module data_memory
    import mem_stage_pkg::*;
#(
    parameter int unsigned DEPTH  = 128,
    parameter int unsigned ADDR_W = 7
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    // Write port
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    // Read port returns the pre-write word during a same-cycle write
    assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/mem_stage.sv
// MIPS MEM stage: branch resolve, wait-stated data memory access, stall, MEM/WB register.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int unsigned DEPTH   = 128,
    parameter int unsigned ADDR_W  = 7,
    parameter int unsigned MEM_LAT = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              WB_RegWrite_i,
    input  logic              WB_MemtoReg_i,
    input  logic              M_branch_i,
    input  logic              M_MemRead_i,
    input  logic              M_MemWrite_i,
    input  logic [DATA_W-1:0] Adder2_i,
    input  logic              zero_i,
    input  logic [DATA_W-1:0] ALU_result_i,
    input  logic [DATA_W-1:0] Write_data_i,
    input  logic [REG_W-1:0]  MUX2_i,
    output logic              PCSrc_o,
    output logic [DATA_W-1:0] branch_target_o,
    output logic              stall_o,
    output logic              WB_RegWrite_o,
    output logic              WB_MemtoReg_o,
    output logic [DATA_W-1:0] Read_data_o,
    output logic [DATA_W-1:0] ALU_result_o,
    output logic [REG_W-1:0]  MUX2_o
);

    localparam int unsigned CNT_W = cnt_width(MEM_LAT);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              access;
    logic              done;
    logic              mem_we;
    logic [ADDR_W-1:0] word_addr;
    logic [DATA_W-1:0] rdata;
    memwb_t            memwb_q, memwb_d;

    assign access    = M_MemRead_i | M_MemWrite_i;
    assign word_addr = ALU_result_i[ADDR_W+1:2];

    // Branch resolution is independent of the access FSM
    assign PCSrc_o         = M_branch_i & zero_i;
    assign branch_target_o = Adder2_i;

    // State and wait counter registers
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state, counter and access-complete decode
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done    = 1'b0;
        if (MEM_LAT == 0) begin
            done = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (access) begin
                        state_d = BUSY;
                        cnt_d   = CNT_W'(MEM_LAT - 1);
                    end
                end
                BUSY: begin
                    if (cnt_q == '0) begin
                        done    = 1'b1;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Stall is forced low while reset is held so the front end is never frozen by a dead access
    assign stall_o = access & ~done & rst_i;
    assign mem_we  = M_MemWrite_i & done;

    data_memory #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_dmem (
        .clk_i   (clk_i),
        .we_i    (mem_we),
        .addr_i  (word_addr),
        .wdata_i (Write_data_i),
        .rdata_o (rdata)
    );

    // MEM/WB next value: bubble while stalled, otherwise capture the instruction
    always_comb begin
        memwb_d = memwb_q;
        if (stall_o) begin
            memwb_d.reg_write = 1'b0;
            memwb_d.memto_reg = 1'b0;
        end else begin
            memwb_d.reg_write  = WB_RegWrite_i;
            memwb_d.memto_reg  = WB_MemtoReg_i;
            memwb_d.read_data  = M_MemRead_i ? rdata : '0;
            memwb_d.alu_result = ALU_result_i;
            memwb_d.dst        = MUX2_i;
        end
    end

    // MEM/WB pipeline register
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            memwb_q <= '0;
        end else begin
            memwb_q <= memwb_d;
        end
    end

    assign WB_RegWrite_o = memwb_q.reg_write;
    assign WB_MemtoReg_o = memwb_q.memto_reg;
    assign Read_data_o   = memwb_q.read_data;
    assign ALU_result_o  = memwb_q.alu_result;
    assign MUX2_o        = memwb_q.dst;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: MEM_LAT=2 main instance plus a MEM_LAT=0 instance.
module tb_mem_stage;

    localparam int unsigned LAT = 2;

    typedef struct {
        logic        rw;
        logic        mtr;
        logic [31:0] rd;
        logic [31:0] alu;
        logic [4:0]  dst;
    } exp_t;

    logic clk;
    logic rst_i;

    // main instance signals
    logic        wb_rw, wb_mtr, br, mr, mw, zf;
    logic [31:0] a2, alu, wd;
    logic [4:0]  dst;
    logic        pcsrc, stall, o_rw, o_mtr;
    logic [31:0] tgt, o_rd, o_alu;
    logic [4:0]  o_dst;

    // zero-latency instance signals
    logic        z_rw, z_mtr, z_mr, z_mw;
    logic [31:0] z_alu, z_wd;
    logic [4:0]  z_dst;
    logic        z_pcsrc, z_stall, zo_rw, zo_mtr;
    logic [31:0] z_tgt, zo_rd, zo_alu;
    logic [4:0]  zo_dst;

    int checks = 0;
    int errors = 0;

    exp_t        q[$];
    exp_t        q0[$];
    logic [31:0] mdl [128];
    logic [31:0] m0  [128];

    logic en     = 1'b0;
    logic en0    = 1'b0;
    logic armed  = 1'b0;
    logic armed0 = 1'b0;
    logic was_stall = 1'b0;

    mem_stage #(.DEPTH(128), .ADDR_W(7), .MEM_LAT(LAT)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .WB_RegWrite_i(wb_rw), .WB_MemtoReg_i(wb_mtr), .M_branch_i(br),
        .M_MemRead_i(mr), .M_MemWrite_i(mw), .Adder2_i(a2), .zero_i(zf),
        .ALU_result_i(alu), .Write_data_i(wd), .MUX2_i(dst),
        .PCSrc_o(pcsrc), .branch_target_o(tgt), .stall_o(stall),
        .WB_RegWrite_o(o_rw), .WB_MemtoReg_o(o_mtr), .Read_data_o(o_rd),
        .ALU_result_o(o_alu), .MUX2_o(o_dst)
    );

    mem_stage #(.DEPTH(128), .ADDR_W(7), .MEM_LAT(0)) dut0 (
        .clk_i(clk), .rst_i(rst_i),
        .WB_RegWrite_i(z_rw), .WB_MemtoReg_i(z_mtr), .M_branch_i(1'b0),
        .M_MemRead_i(z_mr), .M_MemWrite_i(z_mw), .Adder2_i(32'h0), .zero_i(1'b0),
        .ALU_result_i(z_alu), .Write_data_i(z_wd), .MUX2_i(z_dst),
        .PCSrc_o(z_pcsrc), .branch_target_o(z_tgt), .stall_o(z_stall),
        .WB_RegWrite_o(zo_rw), .WB_MemtoReg_o(zo_mtr), .Read_data_o(zo_rd),
        .ALU_result_o(zo_alu), .MUX2_o(zo_dst)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout");
        $fatal(1, "simulation time limit");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h @%0t", nm, act, exp, $time);
        end
    endtask

    task automatic cmp(input string tag, input exp_t e, input logic rwv, input logic mtrv,
                       input logic [31:0] rdv, input logic [31:0] aluv, input logic [4:0] dv);
        chk({tag, "_regwrite"}, 32'(rwv), 32'(e.rw));
        chk({tag, "_memtoreg"}, 32'(mtrv), 32'(e.mtr));
        chk({tag, "_readdata"}, rdv, e.rd);
        chk({tag, "_alu"}, aluv, e.alu);
        chk({tag, "_dst"}, 32'(dv), 32'(e.dst));
    endtask

    // Sample pre-edge stall/arming for the main monitor
    always @(posedge clk) begin
        was_stall <= stall;
        armed     <= rst_i & en;
        armed0    <= rst_i & en0;
    end

    // Main monitor: bubble during stall, otherwise one retired instruction per edge
    always @(negedge clk) begin
        exp_t e;
        if (armed) begin
            if (was_stall) begin
                chk("bubble_regwrite", 32'(o_rw), 32'h0);
                chk("bubble_memtoreg", 32'(o_mtr), 32'h0);
            end else if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output alu=%h exp=none", o_alu);
            end else begin
                e = q.pop_front();
                cmp("memwb", e, o_rw, o_mtr, o_rd, o_alu, o_dst);
            end
        end
    end

    // Zero-latency monitor
    always @(negedge clk) begin
        exp_t e;
        if (armed0) begin
            if (q0.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL lat0_unexpected_output alu=%h exp=none", zo_alu);
            end else begin
                e = q0.pop_front();
                cmp("lat0", e, zo_rw, zo_mtr, zo_rd, zo_alu, zo_dst);
            end
        end
    end

    // Present one instruction at a negedge, wait out the stall, queue its MEM/WB result
    task automatic issue(input logic rw, input logic mtr, input logic brv, input logic zv,
                         input logic rd_en, input logic wr_en, input logic [31:0] a2v,
                         input logic [31:0] aluv, input logic [31:0] wdv, input logic [4:0] dv);
        exp_t       e;
        int         stalls;
        logic [6:0] wa;
        wb_rw = rw; wb_mtr = mtr; br = brv; zf = zv; mr = rd_en; mw = wr_en;
        a2 = a2v; alu = aluv; wd = wdv; dst = dv;
        #1;
        chk("pcsrc", 32'(pcsrc), 32'(brv & zv));
        chk("branch_target", tgt, a2v);
        stalls = 0;
        while (stall && stalls <= int'(2 * LAT + 4)) begin
            @(negedge clk);
            #1;
            stalls++;
        end
        chk("stall_cycles", 32'(stalls), (rd_en | wr_en) ? 32'(LAT) : 32'h0);
        wa    = aluv[8:2];
        e.rw  = rw;
        e.mtr = mtr;
        e.alu = aluv;
        e.dst = dv;
        e.rd  = rd_en ? mdl[wa] : 32'h0;
        if (wr_en) mdl[wa] = wdv;
        q.push_back(e);
        @(negedge clk);
    endtask

    task automatic issue0(input logic rd_en, input logic wr_en, input logic [31:0] aluv,
                          input logic [31:0] wdv, input logic [4:0] dv);
        exp_t       e;
        logic [6:0] wa;
        z_rw = rd_en; z_mtr = rd_en; z_mr = rd_en; z_mw = wr_en;
        z_alu = aluv; z_wd = wdv; z_dst = dv;
        #1;
        chk("lat0_stall", 32'(z_stall), 32'h0);
        wa    = aluv[8:2];
        e.rw  = rd_en;
        e.mtr = rd_en;
        e.alu = aluv;
        e.dst = dv;
        e.rd  = rd_en ? m0[wa] : 32'h0;
        if (wr_en) m0[wa] = wdv;
        q0.push_back(e);
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] r;
        int          kind;
        rst_i = 1'b0;
        wb_rw = 0; wb_mtr = 0; br = 0; mr = 0; mw = 0; zf = 0;
        a2 = 0; alu = 0; wd = 0; dst = 0;
        z_rw = 0; z_mtr = 0; z_mr = 0; z_mw = 0; z_alu = 0; z_wd = 0; z_dst = 0;
        #3;
        chk("reset_regwrite", 32'(o_rw), 32'h0);
        chk("reset_memtoreg", 32'(o_mtr), 32'h0);
        chk("reset_readdata", o_rd, 32'h0);
        chk("reset_alu", o_alu, 32'h0);
        chk("reset_dst", 32'(o_dst), 32'h0);
        chk("reset_stall", 32'(stall), 32'h0);

        @(negedge clk);
        @(negedge clk);
        rst_i = 1'b1;
        en    = 1'b1;

        // fill every word through stores at randomly aliased addresses
        for (int i = 0; i < 128; i++) begin
            r = $urandom;
            issue(1'($urandom), 1'b0, 1'b0, 1'($urandom), 1'b0, 1'b1, $urandom,
                  {r[31:9], 7'(i), r[1:0]}, $urandom, 5'($urandom));
        end

        // random mix of ALU ops, loads, stores, read+write and branches
        for (int i = 0; i < 150; i++) begin
            kind = int'($urandom_range(0, 4));
            issue(1'($urandom), 1'($urandom), kind == 4, 1'($urandom),
                  kind == 1 || kind == 3, kind == 2 || kind == 3,
                  $urandom, $urandom, $urandom, 5'($urandom));
        end

        // load after store
        issue(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h10, 32'hDEADBEEF, 5'd0);
        issue(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h10, 32'h0, 5'd8);
        // branch taken / not taken
        issue(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h40, 32'h0, 32'h0, 5'd0);
        issue(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h40, 32'h0, 32'h0, 5'd0);
        // wrap and byte-offset alignment
        issue(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h203, 32'h1234, 5'd0);
        issue(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h000, 32'h0, 5'd4);
        // read+write together returns the old word
        issue(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h14, 32'hA, 5'd0);
        issue(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0, 32'h14, 32'hB, 5'd5);
        issue(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h14, 32'h0, 5'd6);

        // reset in the middle of a store aborts it
        wb_rw = 0; wb_mtr = 0; br = 0; zf = 0; mr = 0; mw = 1;
        alu = 32'hC; wd = 32'h55; dst = 0;
        #1;
        chk("midstore_stall", 32'(stall), 32'h1);
        @(negedge clk);
        #1;
        rst_i = 1'b0;
        #1;
        chk("midreset_regwrite", 32'(o_rw), 32'h0);
        chk("midreset_memtoreg", 32'(o_mtr), 32'h0);
        chk("midreset_readdata", o_rd, 32'h0);
        chk("midreset_alu", o_alu, 32'h0);
        chk("midreset_dst", 32'(o_dst), 32'h0);
        chk("midreset_stall", 32'(stall), 32'h0);
        @(negedge clk);
        rst_i = 1'b1;
        issue(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'hC, 32'h0, 5'd3);
        en = 1'b0;
        wb_rw = 0; wb_mtr = 0; mr = 0; mw = 0;

        // zero-latency instance: stores then back-to-back loads
        en0 = 1'b1;
        r = $urandom;
        issue0(1'b0, 1'b1, 32'h28, r, 5'd0);
        issue0(1'b0, 1'b1, 32'h2C, ~r, 5'd0);
        issue0(1'b1, 1'b0, 32'h28, 32'h0, 5'd1);
        issue0(1'b1, 1'b0, 32'h2C, 32'h0, 5'd2);
        issue0(1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
        en0 = 1'b0;
        @(negedge clk);
        @(negedge clk);

        chk("queue_drained", 32'(q.size()), 32'h0);
        chk("lat0_queue_drained", 32'(q0.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
